// File: rtl/pack6to8_pkg.sv
// Shared widths and bit-order helpers for the 6<->8 bit pack/unpack stages.
package pack6to8_pkg;

  localparam int unsigned SYM_W     = 6;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ACC_W     = 13;
  localparam int unsigned RD_THRESH = BYTE_W - 1;
  localparam int unsigned NB_W      = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  function automatic logic [SYM_W-1:0] rev_sym(input logic [SYM_W-1:0] s);
    logic [SYM_W-1:0] r;
    for (int i = 0; i < int'(SYM_W); i++) r[i] = s[int'(SYM_W)-1-i];
    return r;
  endfunction

  function automatic logic [BYTE_W-1:0] rev_byte(input logic [BYTE_W-1:0] s);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < int'(BYTE_W); i++) r[i] = s[int'(BYTE_W)-1-i];
    return r;
  endfunction

endpackage

// File: rtl/pack6to8.sv
// Packs 6-bit FIFO symbols into an 8-bit byte stream (4 sextets -> 3 bytes),
// with a one-byte ov/oe output register and a zero-padding flush.
module pack6to8
  import pack6to8_pkg::*;
#(
  parameter bit MSBF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  pdi,
  input  logic              iv,
  output logic              rd,
  output logic [BYTE_W-1:0] pdo,
  output logic              ov,
  input  logic              oe,
  input  logic              flush,
  output logic              fdone
);

  flush_state_e      state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [BYTE_W-1:0] pdo_d;
  logic              ov_d;
  logic              fdone_d;

  logic              nb_low;
  logic              take;
  logic [SYM_W-1:0]  sym_t;
  logic [ACC_W-1:0]  ins_base;
  logic [ACC_W-1:0]  acc_t;
  logic [NB_W-1:0]   nb_t;
  logic [BYTE_W-1:0] byte_t;
  logic              full;
  logic              pad;
  logic              emit;

  // Accumulator is MSB-aligned: oldest bit at acc[ACC_W-1], unused bits kept zero.
  always_comb begin
    state_d  = state_q;
    fdone_d  = 1'b0;
    nb_low   = (nb_q <= NB_W'(RD_THRESH));
    rd       = rst & (state_q == ST_RUN) & nb_low;
    take     = iv & nb_low;
    sym_t    = MSBF ? pdi : rev_sym(pdi);
    ins_base = {sym_t, {(ACC_W-SYM_W){1'b0}}};
    acc_t    = acc_q;
    nb_t     = nb_q;
    if (take) begin
      acc_t = acc_q | (ins_base >> nb_q);
      nb_t  = nb_q + NB_W'(SYM_W);
    end
    byte_t = acc_t[ACC_W-1 -: BYTE_W];
    full   = (nb_t >= NB_W'(BYTE_W));
    pad    = (state_q == ST_FLUSH) & (nb_t != '0);
    emit   = (full | pad) & (~ov | oe);

    acc_d = acc_t;
    nb_d  = nb_t;
    pdo_d = pdo;
    ov_d  = ov & ~oe;
    if (emit) begin
      acc_d = acc_t << BYTE_W;
      nb_d  = full ? (nb_t - NB_W'(BYTE_W)) : '0;
      pdo_d = MSBF ? byte_t : rev_byte(byte_t);
      ov_d  = 1'b1;
    end

    // Flush completes once the buffer is empty; extra flush pulses are ignored.
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (nb_t == '0) begin
          state_d = ST_RUN;
          fdone_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      nb_q    <= '0;
      pdo     <= '0;
      ov      <= 1'b0;
      fdone   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nb_q    <= nb_d;
      pdo     <= pdo_d;
      ov      <= ov_d;
      fdone   <= fdone_d;
    end
  end

endmodule

// File: tb/tb_pack6to8.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share the stimulus.
module tb_pack6to8;

  logic       clk;
  logic       rst;
  logic [5:0] pdi;
  logic       iv;
  logic       oe;
  logic       flush;
  logic       rd_m, ov_m, fdone_m;
  logic       rd_l, ov_l, fdone_l;
  logic [7:0] pdo_m, pdo_l;

  int nerr = 0;
  int nchk = 0;

  bit         bq_m[$];
  bit         bq_l[$];
  logic [7:0] eq_m[$];
  logic [7:0] eq_l[$];

  pack6to8 #(.MSBF(1'b1)) u_msb (
    .clk(clk), .rst(rst), .pdi(pdi), .iv(iv), .rd(rd_m), .pdo(pdo_m),
    .ov(ov_m), .oe(oe), .flush(flush), .fdone(fdone_m)
  );

  pack6to8 #(.MSBF(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .pdi(pdi), .iv(iv), .rd(rd_l), .pdo(pdo_l),
    .ov(ov_l), .oe(oe), .flush(flush), .fdone(fdone_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: bits kept in arrival order, bytes formed 8 at a time.
  task automatic model_bits();
    logic [7:0] b;
    while (bq_m.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bq_m.pop_front()};
      eq_m.push_back(b);
    end
    while (bq_l.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b[i] = bq_l.pop_front();
      eq_l.push_back(b);
    end
  endtask

  task automatic model_push(input logic [5:0] sym);
    for (int i = 5; i >= 0; i--) bq_m.push_back(sym[i]);
    for (int i = 0; i < 6; i++) bq_l.push_back(sym[i]);
    model_bits();
  endtask

  task automatic model_pad();
    while (bq_m.size() % 8 != 0) bq_m.push_back(1'b0);
    while (bq_l.size() % 8 != 0) bq_l.push_back(1'b0);
    model_bits();
  endtask

  task automatic mon_one(input string tag, input logic [7:0] obs, inout logic [7:0] q[$]);
    nchk++;
    assert (q.size() != 0) else begin
      nerr++;
      $error("FAIL %s_extra observed=%h expected=none", tag, obs);
    end
    if (q.size() != 0) chk(tag, obs, q.pop_front());
  endtask

  // One clock: observe transfers at negedge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst && oe) begin
      if (ov_m) mon_one("byte_m", pdo_m, eq_m);
      if (ov_l) mon_one("byte_l", pdo_l, eq_l);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] sym);
    int k;
    k = 0;
    while (!rd_m && k < 50) begin tick(); k++; end
    chk("send_rd", 8'(rd_m), 8'd1);
    iv  = 1'b1;
    pdi = sym;
    model_push(sym);
    tick();
    iv  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((eq_m.size() != 0 || eq_l.size() != 0 || ov_m || ov_l) && k < 50) begin
      tick(); k++;
    end
    chk("drain_q", 8'(eq_m.size() + eq_l.size()), 8'd0);
    chk("drain_ov", 8'(ov_m | ov_l), 8'd0);
  endtask

  task automatic do_flush(input bit with_iv, input logic [5:0] sym);
    int k;
    bit rd_seen;
    flush = 1'b1;
    if (with_iv) begin
      iv  = 1'b1;
      pdi = sym;
      model_push(sym);
    end
    model_pad();
    tick();
    flush   = 1'b0;
    iv      = 1'b0;
    rd_seen = 1'b0;
    k = 0;
    while (!fdone_m && k < 40) begin
      if (rd_m | rd_l) rd_seen = 1'b1;
      tick(); k++;
    end
    chk("fdone_m", 8'(fdone_m), 8'd1);
    chk("fdone_l", 8'(fdone_l), 8'd1);
    chk("flush_rd_low", 8'(rd_seen), 8'd0);
    chk("flush_q_empty", 8'(eq_m.size() + eq_l.size()), 8'd0);
    tick();
    chk("fdone_pulse", 8'(fdone_m | fdone_l), 8'd0);
  endtask

  initial begin
    logic [7:0] first;
    int k;
    rst = 1'b0; iv = 1'b0; oe = 1'b0; flush = 1'b0; pdi = 6'h00;
    tick(); tick();
    chk("rst_ov", 8'(ov_m | ov_l), 8'd0);
    chk("rst_pdo", pdo_m | pdo_l, 8'h00);
    chk("rst_rd", 8'(rd_m | rd_l), 8'd0);
    chk("rst_fdone", 8'(fdone_m | fdone_l), 8'd0);
    rst = 1'b1;
    #1;
    chk("rd_after_rst", 8'(rd_m), 8'd1);

    // Basic packing, both bit orders
    oe = 1'b1;
    send(6'h3F); send(6'h00); send(6'h15); send(6'h2A);
    drain();
    chk("t1_rd_idle", 8'(rd_m), 8'd1);
    send(6'h3F); send(6'h00); send(6'h00); send(6'h00);
    drain();

    // Single sextet then flush -> padded byte
    send(6'h2D);
    do_flush(1'b0, 6'h00);

    // Backpressure: output holds, rd drops, then release
    oe = 1'b0;
    k = 0;
    while (rd_m && k < 10) begin send(6'(k * 7 + 1)); k++; end
    chk("t4_rd_drop", 8'(rd_m), 8'd0);
    first = eq_m[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_pdo", pdo_m, first);
      chk("t4_hold_ov", 8'(ov_m), 8'd1);
    end
    oe = 1'b1;
    send(6'h11); send(6'h22); send(6'h33); send(6'h0C);
    do_flush(1'b0, 6'h00);
    drain();

    // Reset mid-byte with a full output register
    oe = 1'b0;
    send(6'h3F); send(6'h00);
    chk("t5_ov_before", 8'(ov_m), 8'd1);
    rst = 1'b0;
    #1;
    chk("t5_rd_in_rst", 8'(rd_m | rd_l), 8'd0);
    bq_m.delete(); bq_l.delete(); eq_m.delete(); eq_l.delete();
    tick();
    chk("t5_ov", 8'(ov_m | ov_l), 8'd0);
    chk("t5_pdo", pdo_m | pdo_l, 8'h00);
    chk("t5_rd", 8'(rd_m | rd_l), 8'd0);
    rst = 1'b1;
    oe  = 1'b1;
    send(6'h3F); send(6'h00);
    do_flush(1'b0, 6'h00);

    // Flush with empty buffer, then flush coincident with a pop
    do_flush(1'b0, 6'h00);
    do_flush(1'b1, 6'h3F);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
